// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit
//
// Sequencing front-end for the combinational ALU. Takes one operation per
// valid/ready handshake, decodes ALUOp/funct3/funct7[5] into the ALU's 4-bit
// control code, and holds registered operands and control steady toward the
// ALU. One cycle later it captures the ALU result and zero flag. It then
// presents them on a valid/ready response port until they are consumed.
//
// Optional feature macro: ALU_ISSUE_PERF_EN
//   When defined, adds the perf_ops/perf_illegal handshake counters and
//   their ports.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     request handshake (ready only while idle)
//   alu_op, funct3,         operation fields to decode
//   funct7_b5
//   in_a, in_b              request operands
//   operand_a, operand_b    registered operands driven to the ALU
//   alu_control             registered ALU op code (1111 = illegal)
//   alu_result, alu_zero    combinational ALU outputs fed back in
//   out_valid / out_ready   response handshake
//   out_result, out_zero,   captured response fields
//   out_illegal
//   perf_ops, perf_illegal  handshake counters (ALU_ISSUE_PERF_EN only)
// ---------------------------------------------------------------------------
module alu_issue_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic             funct7_b5,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_illegal
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] CODE_AND     = 4'b0000;
  localparam logic [3:0] CODE_OR      = 4'b0001;
  localparam logic [3:0] CODE_ADD     = 4'b0010;
  localparam logic [3:0] CODE_SUB     = 4'b0110;
  localparam logic [3:0] CODE_SLT     = 4'b0111;
  localparam logic [3:0] CODE_ILLEGAL = 4'b1111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] operand_a_q, operand_a_d;
  logic [WIDTH-1:0] operand_b_q, operand_b_d;
  logic [3:0]       alu_control_q, alu_control_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic             out_zero_q, out_zero_d;

  logic [3:0]       dec_code;
  logic             dec_illegal;
  logic             accept;
  logic             resp_done;

  // Decode. Load/store and branch ignore funct fields entirely; only R-type
  // uses funct7[5] to distinguish SUB from ADD. Unsupported funct3 values
  // map to the 1111 code so the ALU produces 0 and the response is flagged.
  always_comb begin
    dec_code    = CODE_ILLEGAL;
    dec_illegal = 1'b1;
    case (alu_op)
      2'b00: begin
        dec_code    = CODE_ADD;
        dec_illegal = 1'b0;
      end
      2'b01: begin
        dec_code    = CODE_SUB;
        dec_illegal = 1'b0;
      end
      default: begin
        dec_illegal = 1'b0;
        case (funct3)
          3'b000: dec_code = (alu_op == 2'b10 && funct7_b5) ? CODE_SUB : CODE_ADD;
          3'b111: dec_code = CODE_AND;
          3'b110: dec_code = CODE_OR;
          3'b010: dec_code = CODE_SLT;
          default: begin
            dec_code    = CODE_ILLEGAL;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign accept    = (state_q == IDLE) && in_valid;
  assign resp_done = (state_q == RESP) && out_ready;

  // Next-state logic. Operands and control only move on an accept, so the
  // ALU sees stable inputs through ISSUE and RESP; the result is sampled in
  // ISSUE and then held for the consumer.
  always_comb begin
    state_d       = state_q;
    operand_a_d   = operand_a_q;
    operand_b_d   = operand_b_q;
    alu_control_d = alu_control_q;
    illegal_d     = illegal_q;
    out_result_d  = out_result_q;
    out_zero_d    = out_zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          operand_a_d   = in_a;
          operand_b_d   = in_b;
          alu_control_d = dec_code;
          illegal_d     = dec_illegal;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        out_result_d = alu_result;
        out_zero_d   = alu_zero;
        state_d      = RESP;
      end
      RESP: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      alu_control_q <= CODE_AND;
      illegal_q     <= 1'b0;
      out_result_q  <= '0;
      out_zero_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      alu_control_q <= alu_control_d;
      illegal_q     <= illegal_d;
      out_result_q  <= out_result_d;
      out_zero_q    <= out_zero_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == RESP);
  assign operand_a   = operand_a_q;
  assign operand_b   = operand_b_q;
  assign alu_control = alu_control_q;
  assign out_result  = out_result_q;
  assign out_zero    = out_zero_q;
  assign out_illegal = illegal_q;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_illegal_q, perf_illegal_d;

  // Counters advance on the response handshake, so a request discarded by
  // reset before delivery is never counted.
  always_comb begin
    perf_ops_d     = perf_ops_q;
    perf_illegal_d = perf_illegal_q;
    if (resp_done) begin
      perf_ops_d = perf_ops_q + 32'd1;
      if (illegal_q) begin
        perf_illegal_d = perf_illegal_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops_q     <= '0;
      perf_illegal_q <= '0;
    end else begin
      perf_ops_q     <= perf_ops_d;
      perf_illegal_q <= perf_illegal_d;
    end
  end

  assign perf_ops     = perf_ops_q;
  assign perf_illegal = perf_illegal_q;
`else
  logic unused_resp_done;
  logic unused_accept;
  assign unused_resp_done = resp_done;
  assign unused_accept    = accept;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [2:0]       funct3;
  logic             funct7_b5;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0]      perf_ops;
  logic [31:0]      perf_illegal;
`endif

  int checkCount;
  int passCount;
  int expOps;
  int expIllegal;

  alu_issue_unit #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_b5   (funct7_b5),
    .in_a        (in_a),
    .in_b        (in_b),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_illegal (out_illegal)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_ops    (perf_ops),
    .perf_illegal(perf_illegal)
`endif
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational ALU sitting behind the unit.
  always_comb begin
    alu_result = '0;
    case (alu_control)
      4'b0010: alu_result = operand_a + operand_b;
      4'b0110: alu_result = operand_a - operand_b;
      4'b0000: alu_result = operand_a & operand_b;
      4'b0001: alu_result = operand_a | operand_b;
      4'b0111: alu_result = (operand_a < operand_b) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  // Single comparison point; every check funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: picks the named operation from the instruction fields,
  // then yields its code and the arithmetic result directly.
  function automatic void refModel(input logic [1:0] op, input logic [2:0] f3,
                                   input logic b5, input logic [31:0] a,
                                   input logic [31:0] b, output logic [3:0] code,
                                   output logic [31:0] res, output logic ill);
    string name;
    if (op == 2'b00) name = "add";
    else if (op == 2'b01) name = "sub";
    else if (f3 == 3'b000) name = (op == 2'b10 && b5) ? "sub" : "add";
    else if (f3 == 3'b111) name = "and";
    else if (f3 == 3'b110) name = "or";
    else if (f3 == 3'b010) name = "slt";
    else name = "illegal";
    ill = 1'b0;
    case (name)
      "add": begin code = 4'd2;  res = a + b; end
      "sub": begin code = 4'd6;  res = a - b; end
      "and": begin code = 4'd0;  res = a & b; end
      "or":  begin code = 4'd1;  res = a | b; end
      "slt": begin code = 4'd7;  res = (a < b) ? 32'd1 : 32'd0; end
      default: begin code = 4'd15; res = 32'd0; ill = 1'b1; end
    endcase
  endfunction

  // Full transaction: wait for ready, issue, check ALU-side and response,
  // apply holdCycles of backpressure (with a competing request offered),
  // then complete the handshake.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3,
                               input logic b5, input logic [31:0] a,
                               input logic [31:0] b, input int holdCycles);
    logic [3:0]  expCode;
    logic [31:0] expRes;
    logic        expIll;
    int          waited;
    refModel(op, f3, b5, a, b, expCode, expRes, expIll);
    waited = 0;
    while (!in_ready && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
    alu_op = op; funct3 = f3; funct7_b5 = b5; in_a = a; in_b = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("alu_control", 32'(alu_control), 32'(expCode));
    checkOutput("operand_a", operand_a, a);
    checkOutput("operand_b", operand_b, b);
    checkOutput("issue_in_ready", 32'(in_ready), 32'd0);
    checkOutput("issue_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("resp_out_valid", 32'(out_valid), 32'd1);
    checkOutput("out_result", out_result, expRes);
    checkOutput("out_zero", 32'(out_zero), 32'(expRes == 32'd0));
    checkOutput("out_illegal", 32'(out_illegal), 32'(expIll));
    for (int i = 0; i < holdCycles; i++) begin
      alu_op = 2'($urandom); funct3 = 3'($urandom);
      in_a = ~a; in_b = ~b; in_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_out_result", out_result, expRes);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_operand_a", operand_a, a);
      checkOutput("bp_alu_control", 32'(alu_control), 32'(expCode));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    expOps++;
    if (expIll) expIllegal++;
    checkOutput("done_out_valid", 32'(out_valid), 32'd0);
    checkOutput("done_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [1:0]  rOp;
    logic [2:0]  rF3;
    logic        rB5;
    logic [31:0] rA;
    logic [31:0] rB;
    checkCount = 0; passCount = 0; expOps = 0; expIllegal = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'b00; funct3 = 3'b000; funct7_b5 = 1'b0; in_a = '0; in_b = '0;

    #3;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_alu_control", 32'(alu_control), 32'd0);
    checkOutput("rst_operand_a", operand_a, 32'd0);
    checkOutput("rst_operand_b", operand_b, 32'd0);
    checkOutput("rst_out_result", out_result, 32'd0);
    checkOutput("rst_out_zero", 32'(out_zero), 32'd0);
    checkOutput("rst_out_illegal", 32'(out_illegal), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed operations");
    applyStimulus(2'b10, 3'b000, 1'b0, 32'd5, 32'd7, 0);
    applyStimulus(2'b01, 3'b101, 1'b1, 32'h1234, 32'h1234, 0);
    applyStimulus(2'b10, 3'b001, 1'b0, 32'd40, 32'd2, 1);
    applyStimulus(2'b11, 3'b010, 1'b1, 32'd3, 32'd9, 0);
    applyStimulus(2'b11, 3'b000, 1'b1, 32'd10, 32'd3, 0);
    applyStimulus(2'b10, 3'b000, 1'b1, 32'd10, 32'd3, 5);

    $display("[TB] reset during response");
    in_a = 32'hdead; in_b = 32'hbeef; alu_op = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_operand_a", operand_a, 32'd0);
    checkOutput("midrst_alu_control", 32'(alu_control), 32'd0);
    checkOutput("midrst_out_result", out_result, 32'd0);
    expOps = 0; expIllegal = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef ALU_ISSUE_PERF_EN
    checkOutput("perf_ops_rst", perf_ops, 32'd0);
    applyStimulus(2'b00, 3'b000, 1'b0, 32'd1, 32'd2, 0);
    applyStimulus(2'b11, 3'b011, 1'b0, 32'd1, 32'd2, 0);
    applyStimulus(2'b10, 3'b111, 1'b0, 32'hf0, 32'h3c, 0);
    applyStimulus(2'b10, 3'b110, 1'b0, 32'hf0, 32'h0f, 0);
    checkOutput("perf_ops_4", perf_ops, 32'd4);
    checkOutput("perf_illegal_1", perf_illegal, 32'd1);
`endif

    $display("[TB] randomized operations");
    for (int n = 0; n < 60; n++) begin
      rOp = 2'($urandom); rF3 = 3'($urandom); rB5 = 1'($urandom);
      rA = $urandom;
      if ($urandom_range(0, 3) == 0) rA = rA & 32'hff;
      rB = ($urandom_range(0, 3) == 0) ? rA : $urandom;
      applyStimulus(rOp, rF3, rB5, rA, rB, $urandom_range(0, 3));
    end

`ifdef ALU_ISSUE_PERF_EN
    checkOutput("perf_ops_final", perf_ops, 32'(expOps));
    checkOutput("perf_illegal_final", perf_illegal, 32'(expIllegal));
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
